// File: rtl/me_pkg.sv
// me_pkg: shared state enum, widths, vector type and invalid-SAD marker for the ME job sequencer
package me_pkg;
    localparam int ME_DATA_W = 64;
    localparam int ME_CUR_AW = 5;
    localparam int ME_REF_AW = 7;
    localparam int ME_R_MAX = 8;
    localparam logic [15:0] ME_SAD_INVALID = 16'hFFFF;
    typedef logic signed [4:0] me_mv_t;
    typedef enum logic [2:0] {
        ME_IDLE,
        ME_LOAD_CUR,
        ME_LOAD_REF,
        ME_KICK,
        ME_SEARCH,
        ME_FINISH
    } me_job_state_t;
endpackage

// File: rtl/me_load_ctr.sv
// me_load_ctr: word counter advanced by an accepted handshake; flags and wraps on the last word
// Ports: clk, reset (sync, active-high), en_i (accepted word), last_i (index of final word),
//        count_o (address of the current word), done_o (final word accepted this cycle)
module me_load_ctr
    import me_pkg::*;
#(
    parameter int AW = ME_REF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [AW-1:0] last_i,
    output logic [AW-1:0] count_o,
    output logic          done_o
);
    logic [AW-1:0] count_q, count_d;
    assign done_o  = en_i && count_q == last_i;
    assign count_d = done_o ? '0 : en_i ? count_q + 1'b1 : count_q;
    assign count_o = count_q;
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/me_job_sequencer.sv
// me_job_sequencer: per-macroblock job controller that loads cur/ref buffers, runs the ME search and returns its result
// Ports: clk, reset (sync, active-high); job_start/job_r request a job; in_valid/in_data/in_ready stream
//        32 cur words then 128 ref words into the cur_*/ref_* write ports; me_r/me_start drive the engine,
//        me_done/me_mv_x/me_mv_y/me_sad return its result; busy, job_done, mv_x, mv_y, sad, timeout_err
//        report to the frame controller.
// Build option: ME_JOB_SEQUENCER_PERF_EN adds job_cycles, a saturating job length counter.
module me_job_sequencer
    import me_pkg::*;
#(
    parameter int DATA_W  = ME_DATA_W,
    parameter int CUR_AW  = ME_CUR_AW,
    parameter int REF_AW  = ME_REF_AW,
    parameter int R_MAX   = ME_R_MAX,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_start,
    input  logic [3:0]        job_r,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cur_we,
    output logic [CUR_AW-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_wdata,
    output logic              ref_we,
    output logic [REF_AW-1:0] ref_addr,
    output logic [DATA_W-1:0] ref_wdata,
    output logic [3:0]        me_r,
    output logic              me_start,
    input  logic              me_done,
    input  logic signed [4:0] me_mv_x,
    input  logic signed [4:0] me_mv_y,
    input  logic [15:0]       me_sad,
    output logic              busy,
    output logic              job_done,
    output logic signed [4:0] mv_x,
    output logic signed [4:0] mv_y,
    output logic [15:0]       sad,
    output logic              timeout_err
`ifdef ME_JOB_SEQUENCER_PERF_EN
    ,
    output logic [15:0]       job_cycles
`endif
);
    localparam int CUR_WORDS = 2 ** CUR_AW;
    localparam int REF_WORDS = 2 ** REF_AW;
    localparam int TW = $clog2(TIMEOUT);
    me_job_state_t state_q, state_d;
    logic [3:0] r_q, r_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    me_mv_t mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [15:0] sad_q, sad_d;
    logic to_q, to_d;
    logic acc, ld_done, expired;
    logic [REF_AW-1:0] cnt, ld_last;
    assign in_ready = state_q == ME_LOAD_CUR || state_q == ME_LOAD_REF;
    assign acc      = in_valid && in_ready;
    assign ld_last  = state_q == ME_LOAD_CUR ? REF_AW'(CUR_WORDS - 1) : REF_AW'(REF_WORDS - 1);
    me_load_ctr #(.AW(REF_AW)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (acc),
        .last_i  (ld_last),
        .count_o (cnt),
        .done_o  (ld_done)
    );
    assign cur_we    = acc && state_q == ME_LOAD_CUR;
    assign ref_we    = acc && state_q == ME_LOAD_REF;
    assign cur_addr  = cur_we ? cnt[CUR_AW-1:0] : '0;
    assign ref_addr  = ref_we ? cnt : '0;
    assign cur_wdata = cur_we ? in_data : '0;
    assign ref_wdata = ref_we ? in_data : '0;
    assign me_r      = state_q == ME_KICK || state_q == ME_SEARCH ? r_q : '0;
    assign me_start  = state_q == ME_KICK;
    assign busy      = state_q != ME_IDLE && state_q != ME_FINISH;
    assign job_done  = state_q == ME_FINISH;
    assign mv_x        = mv_x_q;
    assign mv_y        = mv_y_q;
    assign sad         = sad_q;
    assign timeout_err = to_q;
    // The search counter starts at 1 in KICK so it measures cycles since me_start.
    assign tcnt_d  = state_q == ME_SEARCH ? tcnt_q + 1'b1 : state_q == ME_KICK ? TW'(1) : '0;
    assign expired = tcnt_q == TW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        mv_x_d  = mv_x_q;
        mv_y_d  = mv_y_q;
        sad_d   = sad_q;
        to_d    = to_q;
        case (state_q)
            ME_IDLE: if (job_start) begin
                r_d     = job_r > 4'(R_MAX) ? 4'(R_MAX) : job_r;
                state_d = ME_LOAD_CUR;
            end
            ME_LOAD_CUR: state_d = ld_done ? ME_LOAD_REF : ME_LOAD_CUR;
            ME_LOAD_REF: state_d = ld_done ? ME_KICK : ME_LOAD_REF;
            ME_KICK:     state_d = ME_SEARCH;
            ME_SEARCH: if (me_done || expired) begin
                // A completion arriving on the expiry cycle still counts as a result.
                mv_x_d  = me_done ? me_mv_x : '0;
                mv_y_d  = me_done ? me_mv_y : '0;
                sad_d   = me_done ? me_sad : ME_SAD_INVALID;
                to_d    = !me_done;
                state_d = ME_FINISH;
            end
            default: state_d = ME_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ME_IDLE;
            r_q     <= '0;
            tcnt_q  <= '0;
            mv_x_q  <= '0;
            mv_y_q  <= '0;
            sad_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            tcnt_q  <= tcnt_d;
            mv_x_q  <= mv_x_d;
            mv_y_q  <= mv_y_d;
            sad_q   <= sad_d;
            to_q    <= to_d;
        end
    end
`ifdef ME_JOB_SEQUENCER_PERF_EN
    logic [15:0] cyc_q, cyc_d;
    // Loaded with 2 so the value seen in each cycle already includes that cycle and the start cycle.
    assign cyc_d = state_q == ME_IDLE && job_start ? 16'd2 :
                   busy && cyc_q != 16'hFFFF ? cyc_q + 16'd1 : cyc_q;
    assign job_cycles = cyc_q;
    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end
`endif
endmodule

// File: tb/tb_me_job_sequencer.sv
// tb_me_job_sequencer: table-driven, hand-sequenced and randomized jobs checked against a job-level model
module tb_me_job_sequencer;
    logic clk = 1'b0, reset = 1'b1, job_start = 1'b0, in_valid = 1'b0, me_done = 1'b0;
    logic [3:0] job_r = '0;
    logic [63:0] in_data = '0;
    logic signed [4:0] me_mv_x = '0, me_mv_y = '0;
    logic [15:0] me_sad = '0;
    logic in_ready, cur_we, ref_we, me_start, busy, job_done, timeout_err;
    logic [4:0] cur_addr;
    logic [6:0] ref_addr;
    logic [63:0] cur_wdata, ref_wdata;
    logic [3:0] me_r;
    logic signed [4:0] mv_x, mv_y;
    logic [15:0] sad;
`ifdef ME_JOB_SEQUENCER_PERF_EN
    logic [15:0] job_cycles;
`endif

    me_job_sequencer #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .job_start(job_start), .job_r(job_r),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_wdata(cur_wdata),
        .ref_we(ref_we), .ref_addr(ref_addr), .ref_wdata(ref_wdata),
        .me_r(me_r), .me_start(me_start), .me_done(me_done),
        .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_sad(me_sad),
        .busy(busy), .job_done(job_done), .mv_x(mv_x), .mv_y(mv_y), .sad(sad),
        .timeout_err(timeout_err)
`ifdef ME_JOB_SEQUENCER_PERF_EN
        , .job_cycles(job_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r; int lat; logic [4:0] mvx; logic [4:0] mvy; logic [15:0] sad;
        int mode; bit extra; int tag;
        logic [3:0] e_mr; logic [4:0] e_mvx; logic [4:0] e_mvy; logic [15:0] e_sad; logic e_to;
        int e_start; int e_done;
    } job_t;

    int errors = 0, checks = 0, cyc = 0, c0 = 0;
    logic [63:0] words [160];
    bit vpat [2048];
    int li = 0, widx = 0;
    bit feed_en = 0, in_job = 0;
    int eng_lat = 0, eng_cnt = 0;
    logic [4:0] eng_mvx = '0, eng_mvy = '0;
    logic [15:0] eng_sad = '0;
    logic [63:0] cur_mem [32];
    logic [63:0] ref_mem [128];
    int cur_n = 0, ref_n = 0, order_err = 0, start_n = 0, start_cyc = 0, done_n = 0, done_cyc = 0;
    int busy_err = 0, mer_err = 0;
    logic [3:0] start_mr = '0, exp_mr = '0;
    logic [4:0] cap_mvx = '0, cap_mvy = '0;
    logic [15:0] cap_sad = '0, cap_cyc = '0;
    logic cap_to = 1'b0;
    job_t tbl [6];
    job_t j;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream source, engine model and write/pulse monitor share one loop so their order is fixed.
    initial forever begin
        @(negedge clk);
        if (feed_en && in_ready === 1'b1) begin
            in_valid = vpat[li] && widx < 160;
            in_data  = words[widx < 160 ? widx : 0];
            li++;
            if (in_valid) widx++;
        end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom};
        end
        me_done = 1'b0;
        me_mv_x = 5'($urandom);
        me_mv_y = 5'($urandom);
        me_sad  = 16'($urandom);
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                me_done = 1'b1; me_mv_x = eng_mvx; me_mv_y = eng_mvy; me_sad = eng_sad;
            end
        end else if (busy === 1'b0 && $urandom_range(0, 3) == 0) me_done = 1'b1;
        #1;
        if (me_start) begin
            start_n++; start_cyc = cyc; start_mr = me_r;
            if (eng_lat > 0) eng_cnt = eng_lat;
        end
        if (cur_we && ref_we) order_err++;
        if (cur_we) begin
            if (int'(cur_addr) != cur_n || ref_n != 0) order_err++;
            cur_mem[cur_addr] = cur_wdata; cur_n++;
        end
        if (ref_we) begin
            if (int'(ref_addr) != ref_n || cur_n != 32) order_err++;
            ref_mem[ref_addr] = ref_wdata; ref_n++;
        end
        if (in_job && start_n > 0 && done_n == 0 && !job_done && me_r != exp_mr) mer_err++;
        if (in_job && cyc > c0 && done_n == 0 && !job_done && !busy) busy_err++;
        if (job_done) begin
            done_n++; done_cyc = cyc;
            cap_mvx = mv_x; cap_mvy = mv_y; cap_sad = sad; cap_to = timeout_err;
            if (busy) busy_err++;
`ifdef ME_JOB_SEQUENCER_PERF_EN
            cap_cyc = job_cycles;
`endif
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " ctl outputs"}, {in_ready, cur_we, ref_we, me_start, busy, job_done, timeout_err,
             cur_addr, ref_addr, me_r, mv_x, mv_y, sad}, 64'd0);
        chk({nm, " wdata outputs"}, cur_wdata | ref_wdata, 64'd0);
`ifdef ME_JOB_SEQUENCER_PERF_EN
        chk({nm, " job_cycles"}, job_cycles, 64'd0);
`endif
    endtask

    // Number of load cycles needed to accept all 160 words under the valid pattern.
    function automatic int load_cycles();
        int n = 0, got = 0;
        while (got < 160) begin
            got += int'(vpat[n]);
            n++;
        end
        return n;
    endfunction

    task automatic run_job(input job_t jb, input string nm);
        int mm = 0;
        bit extra_sent = 0;
        for (int i = 0; i < 160; i++)
            words[i] = jb.mode == 2 ? {$urandom, $urandom} : ((64'(jb.tag) << 40) | 64'(i));
        if (jb.mode == 0) for (int i = 0; i < 2048; i++) vpat[i] = 1'b1;
        if (jb.mode == 1) for (int i = 0; i < 2048; i++) vpat[i] = (i % 2) == 0;
        for (int i = 0; i < 32; i++) cur_mem[i] = 'x;
        for (int i = 0; i < 128; i++) ref_mem[i] = 'x;
        cur_n = 0; ref_n = 0; order_err = 0; start_n = 0; done_n = 0; busy_err = 0; mer_err = 0;
        li = 0; widx = 0; exp_mr = jb.e_mr; eng_lat = jb.lat; eng_cnt = 0;
        eng_mvx = jb.mvx; eng_mvy = jb.mvy; eng_sad = jb.sad; feed_en = 1;
        @(negedge clk);
        job_start = 1'b1; job_r = jb.r; c0 = cyc; in_job = 1;
        @(negedge clk);
        job_start = 1'b0; job_r = 4'($urandom);
        for (int k = 0; k < 4000 && done_n == 0; k++) begin
            @(negedge clk);
            if (jb.extra && !extra_sent && ref_n > 10) begin
                job_start = 1'b1; job_r = 4'd2; extra_sent = 1;
            end else job_start = 1'b0;
        end
        job_start = 1'b0;
        #2;
        for (int i = 0; i < 32; i++) if (cur_mem[i] !== words[i]) mm++;
        for (int i = 0; i < 128; i++) if (ref_mem[i] !== words[32 + i]) mm++;
        chk({nm, " cur writes"}, cur_n, 32);
        chk({nm, " ref writes"}, ref_n, 128);
        chk({nm, " buffer data mismatches"}, mm, 0);
        chk({nm, " address order errors"}, order_err, 0);
        chk({nm, " me_start pulses"}, start_n, 1);
        chk({nm, " me_start delay"}, start_cyc - c0, jb.e_start);
        chk({nm, " me_r at start"}, start_mr, jb.e_mr);
        chk({nm, " me_r instability"}, mer_err, 0);
        chk({nm, " job_done pulses"}, done_n, 1);
        chk({nm, " job_done delay"}, done_cyc - c0, jb.e_done);
        chk({nm, " mv_x"}, cap_mvx, jb.e_mvx);
        chk({nm, " mv_y"}, cap_mvy, jb.e_mvy);
        chk({nm, " sad"}, cap_sad, jb.e_sad);
        chk({nm, " timeout_err"}, cap_to, jb.e_to);
        chk({nm, " busy errors"}, busy_err, 0);
        chk({nm, " done/busy after finish"}, {job_done, busy}, 0);
`ifdef ME_JOB_SEQUENCER_PERF_EN
        chk({nm, " job_cycles"}, cap_cyc, jb.e_done + 1);
`endif
        in_job = 0;
        repeat (6) @(negedge clk);
        #2;
        chk({nm, " result hold"}, {mv_x, mv_y, sad, timeout_err}, {jb.e_mvx, jb.e_mvy, jb.e_sad, jb.e_to});
        chk({nm, " idle after job"}, {busy, done_n}, {1'b0, 32'd1});
    endtask

    initial begin
        tbl[0] = '{4'd3,  20, 5'h1E, 5'h01, 16'h0123, 0, 0, 0, 4'd3, 5'h1E, 5'h01, 16'h0123, 1'b0, 161, 182};
        tbl[1] = '{4'd5,  20, 5'h03, 5'h1C, 16'h0456, 1, 0, 1, 4'd5, 5'h03, 5'h1C, 16'h0456, 1'b0, 320, 341};
        tbl[2] = '{4'd15,  5, 5'h07, 5'h18, 16'h0010, 0, 1, 2, 4'd8, 5'h07, 5'h18, 16'h0010, 1'b0, 161, 167};
        tbl[3] = '{4'd0,   0, 5'h09, 5'h09, 16'h0999, 0, 0, 3, 4'd0, 5'h00, 5'h00, 16'hFFFF, 1'b1, 161, 225};
        tbl[4] = '{4'd8,  63, 5'h01, 5'h01, 16'h0042, 0, 0, 4, 4'd8, 5'h01, 5'h01, 16'h0042, 1'b0, 161, 225};
        tbl[5] = '{4'd9,  62, 5'h10, 5'h0F, 16'hFFFE, 0, 0, 5, 4'd8, 5'h10, 5'h0F, 16'hFFFE, 1'b0, 161, 224};
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 160; i++) words[i] = 64'(i);
        for (int i = 0; i < 2048; i++) vpat[i] = 1'b1;
        li = 0; widx = 0; cur_n = 0; ref_n = 0; eng_lat = 0; eng_cnt = 0; in_job = 0; feed_en = 1;
        @(negedge clk);
        job_start = 1'b1; job_r = 4'd7;
        @(negedge clk);
        job_start = 1'b0;
        for (int k = 0; k < 300 && cur_n + ref_n < 50; k++) @(negedge clk);
        chk("abort at word 50", cur_n + ref_n, 50);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check_zero("abort");
        reset = 1'b0;
        run_job(tbl[0], "post-reset");

        for (int n = 0; n < 10; n++) begin
            int lc;
            bit ok;
            j.r = 4'($urandom); j.lat = $urandom_range(0, 90);
            j.mvx = 5'($urandom); j.mvy = 5'($urandom); j.sad = 16'($urandom);
            j.mode = 2; j.extra = 0; j.tag = 16 + n;
            for (int i = 0; i < 2048; i++) vpat[i] = i >= 600 ? 1'b1 : $urandom_range(0, 9) < 7;
            lc = load_cycles();
            ok = j.lat > 0 && j.lat <= 63;
            j.e_mr = j.r > 4'd8 ? 4'd8 : j.r;
            j.e_mvx = ok ? j.mvx : 5'd0;
            j.e_mvy = ok ? j.mvy : 5'd0;
            j.e_sad = ok ? j.sad : 16'hFFFF;
            j.e_to = !ok;
            j.e_start = 1 + lc;
            j.e_done = j.e_start + (ok ? j.lat + 1 : 64);
            run_job(j, $sformatf("rand%0d", n));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
        $fatal(1);
    end
endmodule
